// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle ARMv8 core: next-PC selection,
// stall/redirect handling and a small circular return-address stack.
module pc_sequencer #(
    parameter int                ADDR_W       = 64,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    input  logic [2:0]        BranchMode,
    input  logic              ALUZero,
    input  logic [ADDR_W-1:0] SignExt,
    input  logic [ADDR_W-1:0] RegTarget,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] LinkAddr,
    output logic              RasEmpty,
    output logic              RasFull,
    output logic              AlignFault
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        MODE_SEQ  = 3'd0,
        MODE_B    = 3'd1,
        MODE_CBZ  = 3'd2,
        MODE_CBNZ = 3'd3,
        MODE_BR   = 3'd4,
        MODE_BL   = 3'd5,
        MODE_RET  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [CNT_W-1:0]  ras_cnt;
    logic              align_fault;
    logic              fault_nxt;
    logic              push;
    logic              pop;

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] reg_tgt;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [ADDR_W-1:0] ras_top;

    // All address arithmetic wraps modulo 2^ADDR_W by construction.
    assign seq_pc       = pc + ADDR_W'(4);
    assign branch_tgt   = pc + (SignExt << 2);
    assign reg_tgt      = {RegTarget[ADDR_W-1:2], 2'b00};
    assign redirect_tgt = {RedirectPC[ADDR_W-1:2], 2'b00};
    assign ras_top      = ras_mem[ras_ptr - PTR_W'(1)];

    always_comb begin
        pc_nxt    = pc;
        fault_nxt = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        if (Redirect) begin
            pc_nxt    = redirect_tgt;
            fault_nxt = |RedirectPC[1:0];
        end else if (!Stall) begin
            case (mode_e'(BranchMode))
                MODE_B:    pc_nxt = branch_tgt;
                MODE_CBZ:  pc_nxt = ALUZero ? branch_tgt : seq_pc;
                MODE_CBNZ: pc_nxt = ALUZero ? seq_pc : branch_tgt;
                MODE_BR: begin
                    pc_nxt    = reg_tgt;
                    fault_nxt = |RegTarget[1:0];
                end
                MODE_BL: begin
                    pc_nxt = branch_tgt;
                    push   = 1'b1;
                end
                MODE_RET: begin
                    if (ras_cnt != '0) begin
                        pc_nxt = ras_top;
                        pop    = 1'b1;
                    end else begin
                        pc_nxt    = reg_tgt;
                        fault_nxt = |RegTarget[1:0];
                    end
                end
                default:   pc_nxt = seq_pc;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc          <= RESET_VECTOR;
            ras_ptr     <= '0;
            ras_cnt     <= '0;
            align_fault <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            align_fault <= fault_nxt;
            if (push) begin
                // A push into a full stack overwrites the oldest entry.
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_cnt != CNT_MAX) ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (pop) begin
                ras_ptr <= ras_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) ras_mem[ras_ptr] <= seq_pc;
    end

    assign PC         = pc;
    assign LinkAddr   = seq_pc;
    assign RasEmpty   = (ras_cnt == '0);
    assign RasFull    = (ras_cnt == CNT_MAX);
    assign AlignFault = align_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: sequential flow, conditional branches,
// call/return with RAS overflow, stall versus redirect and asynchronous reset.
module tb_pc_sequencer;

    localparam logic [63:0] RV = 64'h1000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [63:0] RedirectPC = '0;
    logic [2:0]  BranchMode = 3'd0;
    logic        ALUZero = 1'b0;
    logic [63:0] SignExt = '0;
    logic [63:0] RegTarget = '0;
    logic [63:0] PC;
    logic [63:0] LinkAddr;
    logic        RasEmpty;
    logic        RasFull;
    logic        AlignFault;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    pc_sequencer #(.ADDR_W(64), .RESET_VECTOR(RV), .RAS_DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .BranchMode(BranchMode), .ALUZero(ALUZero),
        .SignExt(SignExt), .RegTarget(RegTarget), .PC(PC), .LinkAddr(LinkAddr),
        .RasEmpty(RasEmpty), .RasFull(RasFull), .AlignFault(AlignFault)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks: set inputs, then advance to 1 time unit past the next rising edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] mode, input logic [63:0] se,
                         input logic [63:0] rt, input logic z);
        Redirect   = 1'b0;
        BranchMode = mode;
        SignExt    = se;
        RegTarget  = rt;
        ALUZero    = z;
        cyc();
    endtask

    task automatic redirect_to(input logic [63:0] addr);
        Redirect   = 1'b1;
        RedirectPC = addr;
        cyc();
        Redirect   = 1'b0;
    endtask

    initial begin
        // Reset asserted asynchronously between edges
        #2 Rst = 1'b1;
        #1;
        chk("reset_pc", PC, RV);
        chk("reset_link", LinkAddr, RV + 64'h4);
        chk("reset_empty", {63'd0, RasEmpty}, 64'd1);
        chk("reset_full", {63'd0, RasFull}, 64'd0);
        chk("reset_fault", {63'd0, AlignFault}, 64'd0);
        cyc();
        chk("reset_hold", PC, RV);
        Rst = 1'b0;

        drive(3'd0, '0, '0, 1'b0); chk("seq1", PC, 64'h1004);
        drive(3'd0, '0, '0, 1'b0); chk("seq2", PC, 64'h1008);
        drive(3'd0, '0, '0, 1'b0); chk("seq3", PC, 64'h100C);

        // Conditional branches from 0x2000 with offset -2 words
        redirect_to(64'h2000);
        chk("redir_2000", PC, 64'h2000);
        chk("redir_nofault", {63'd0, AlignFault}, 64'd0);
        drive(3'd2, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b1); chk("cbz_taken", PC, 64'h1FF8);
        drive(3'd2, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b0); chk("cbz_not", PC, 64'h1FFC);
        drive(3'd3, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b0); chk("cbnz_taken", PC, 64'h1FF4);
        drive(3'd3, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b1); chk("cbnz_not", PC, 64'h1FF8);
        drive(3'd1, 64'h3, '0, 1'b0); chk("b_fwd", PC, 64'h2004);

        // Wrap-around and reserved mode
        redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_link", LinkAddr, 64'h0);
        drive(3'd0, '0, '0, 1'b0); chk("wrap_pc", PC, 64'h0);
        drive(3'd7, 64'h55, 64'h777, 1'b1); chk("rsvd_seq", PC, 64'h4);

        // Call / return
        redirect_to(64'h100);
        chk("bl_link", LinkAddr, 64'h104);
        drive(3'd5, 64'h40, '0, 1'b0);
        chk("bl_pc", PC, 64'h200);
        chk("bl_nonempty", {63'd0, RasEmpty}, 64'd0);
        drive(3'd6, '0, 64'h9990, 1'b0);
        chk("ret_pc", PC, 64'h104);
        chk("ret_empty", {63'd0, RasEmpty}, 64'd1);
        drive(3'd6, '0, 64'h3003, 1'b0);
        chk("ret_fallback", PC, 64'h3000);
        chk("ret_fault", {63'd0, AlignFault}, 64'd1);
        drive(3'd0, '0, '0, 1'b0);
        chk("fault_pulse_end", {63'd0, AlignFault}, 64'd0);
        chk("seq_after_fault", PC, 64'h3004);
        drive(3'd4, '0, 64'h4000, 1'b0);
        chk("br_pc", PC, 64'h4000);
        chk("br_nofault", {63'd0, AlignFault}, 64'd0);
        drive(3'd4, '0, 64'h4442, 1'b0);
        chk("br_mis_pc", PC, 64'h4440);
        chk("br_mis_fault", {63'd0, AlignFault}, 64'd1);
        redirect_to(64'h5001);
        chk("redir_mis_pc", PC, 64'h5000);
        chk("redir_mis_fault", {63'd0, AlignFault}, 64'd1);

        // RAS overflow: five calls A..E each 0x400 apart, oldest entry lost
        redirect_to(64'h6000);
        for (int i = 0; i < 5; i++) begin
            drive(3'd5, 64'h100, '0, 1'b0);
            if (i == 2) chk("ras_not_full", {63'd0, RasFull}, 64'd0);
        end
        chk("ovf_pc", PC, 64'h7400);
        chk("ovf_full", {63'd0, RasFull}, 64'd1);
        exp_q = '{64'h7004, 64'h6C04, 64'h6804, 64'h6404};
        while (exp_q.size() > 0) begin
            drive(3'd6, '0, 64'hDEAD_0000, 1'b0);
            chk("ovf_ret", PC, exp_q.pop_front());
        end
        chk("ovf_empty", {63'd0, RasEmpty}, 64'd1);
        chk("ovf_notfull", {63'd0, RasFull}, 64'd0);
        drive(3'd6, '0, 64'h9000, 1'b0);
        chk("ovf_fallback", PC, 64'h9000);

        // Stall versus redirect
        drive(3'd5, 64'h10, '0, 1'b0);
        chk("stall_pre", PC, 64'h9040);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'd1, 64'h10, '0, 1'b0);
            chk("stall_b_pc", PC, 64'h9040);
            chk("stall_b_ras", {63'd0, RasEmpty}, 64'd0);
        end
        drive(3'd6, '0, 64'h1234, 1'b0);
        chk("stall_ret_pc", PC, 64'h9040);
        chk("stall_ret_ras", {63'd0, RasEmpty}, 64'd0);
        BranchMode = 3'd6;
        redirect_to(64'h8000);
        chk("stall_redir_pc", PC, 64'h8000);
        chk("stall_redir_ras", {63'd0, RasEmpty}, 64'd0);
        Stall = 1'b0;
        drive(3'd6, '0, 64'h1234, 1'b0);
        chk("post_stall_ret", PC, 64'h9004);
        chk("post_stall_empty", {63'd0, RasEmpty}, 64'd1);

        // Reset in the middle of a call stack
        redirect_to(64'hA000);
        drive(3'd5, 64'h1, '0, 1'b0);
        drive(3'd5, 64'h1, '0, 1'b0);
        chk("mid_pc", PC, 64'hA008);
        chk("mid_nonempty", {63'd0, RasEmpty}, 64'd0);
        #2 Rst = 1'b1;
        #1;
        chk("mid_rst_pc", PC, RV);
        chk("mid_rst_empty", {63'd0, RasEmpty}, 64'd1);
        Rst = 1'b0;
        drive(3'd6, '0, 64'hB000, 1'b0);
        chk("mid_rst_ret", PC, 64'hB000);
        chk("mid_rst_ret_empty", {63'd0, RasEmpty}, 64'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
